// File: rtl/iterative_divider_if.sv
// Request/result bundle for the iterative divider.
// The master issues start with operands; the slave returns a registered result with a done pulse.
interface iterative_divider_if #(
    parameter int N = 64
);
    logic         start;
    logic         is_signed;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/iterative_divider.sv
// Restoring shift-subtract divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Latency N+2 cycles start-to-done (1 cycle for divide-by-zero and signed overflow).
// No backpressure: start is only accepted in IDLE; the issuer stalls while busy is high.
module iterative_divider #(
    parameter int N = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    iterative_divider_if.slave bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] rem_q, rem_d;
    logic [N-1:0] quo_q, quo_d;
    logic [N-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         neg_quo_q, neg_quo_d;
    logic         neg_rem_q, neg_rem_d;
    logic [N-1:0] quotient_q, quotient_d;
    logic [N-1:0] remainder_q, remainder_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         dbz_q, dbz_d;

    logic         sign_a, sign_b;
    logic [N-1:0] abs_a, abs_b;
    logic [N:0]   rem_sh, trial;

    always_comb begin
        sign_a = bus.is_signed & bus.dividend[N-1];
        sign_b = bus.is_signed & bus.divisor[N-1];
        abs_a  = sign_a ? -bus.dividend : bus.dividend;
        abs_b  = sign_b ? -bus.divisor  : bus.divisor;
        // trial[N] set means the shifted remainder is smaller than the divisor
        rem_sh = {rem_q, quo_q[N-1]};
        trial  = rem_sh - {1'b0, dvs_q};

        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    if (bus.divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                        state_d     = DONE;
                    end else if (bus.is_signed && bus.dividend == {1'b1, {(N-1){1'b0}}}
                                 && bus.divisor == '1) begin
                        quotient_d  = bus.dividend;
                        remainder_d = '0;
                        dbz_d       = 1'b0;
                        done_d      = 1'b1;
                        state_d     = DONE;
                    end else begin
                        neg_quo_d = sign_a ^ sign_b;
                        neg_rem_d = sign_a;
                        quo_d     = abs_a;
                        dvs_d     = abs_b;
                        rem_d     = '0;
                        cnt_d     = CW'(N - 1);
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                if (trial[N]) begin
                    rem_d = rem_sh[N-1:0];
                    quo_d = {quo_q[N-2:0], 1'b0};
                end else begin
                    rem_d = trial[N-1:0];
                    quo_d = {quo_q[N-2:0], 1'b1};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                quotient_d  = neg_quo_q ? -quo_q : quo_q;
                remainder_d = neg_rem_q ? -rem_q : rem_q;
                dbz_d       = 1'b0;
                done_d      = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider (N=64): directed corner cases, protocol, reset, random.
module tb_iterative_divider;
    localparam int N   = 64;
    localparam int LAT = N + 2;

    logic clk;
    logic rst_n;

    iterative_divider_if #(.N(N)) bus ();

    iterative_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        exp_t e;
        e.dbz = 1'b0;
        e.lat = LAT;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1;
        end else if (s && a == {1'b1, {(N-1){1'b0}}} && b == '1) begin
            e.q = a; e.r = '0; e.lat = 1;
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // poke > 0: pulse start with other operands in that cycle after acceptance
    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic s, input int poke);
        exp_t e;
        int   lat;
        logic seen, busy_all;
        sb.push_back(model(a, b, s));
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b; bus.is_signed = s;
        @(posedge clk);
        lat = 0; seen = 1'b0; busy_all = 1'b1;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            bus.start = (lat == poke);
            if (lat == poke) begin
                bus.dividend = 64'd999; bus.divisor = 64'd5; bus.is_signed = ~s;
            end
            if (bus.busy !== 1'b1) busy_all = 1'b0;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        bus.start = 1'b0;
        chk({tag, ":done_seen"}, N'(seen), N'(1'b1));
        e = sb.pop_front();
        chk({tag, ":latency"}, N'(lat), N'(e.lat));
        chk({tag, ":busy_through"}, N'(busy_all), N'(1'b1));
        chk({tag, ":quotient"}, bus.quotient, e.q);
        chk({tag, ":remainder"}, bus.remainder, e.r);
        chk({tag, ":div_by_zero"}, N'(bus.div_by_zero), N'(e.dbz));
        @(negedge clk);
        chk({tag, ":busy_after"}, N'(bus.busy), '0);
        chk({tag, ":done_once"}, N'(bus.done), '0);
    endtask

    initial begin
        logic no_done;
        logic [N-1:0] ra, rb;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst:busy", N'(bus.busy), '0);
        chk("rst:done", N'(bus.done), '0);
        chk("rst:quotient", bus.quotient, '0);
        chk("rst:remainder", bus.remainder, '0);
        chk("rst:dbz", N'(bus.div_by_zero), '0);
        rst_n = 1'b1;

        run_op("u100_7",   64'd100, 64'd7, 1'b0, 0);
        run_op("s-100_7",  -64'sd100, 64'd7, 1'b1, 0);
        run_op("s100_-7",  64'd100, -64'sd7, 1'b1, 0);
        run_op("s-100_-7", -64'sd100, -64'sd7, 1'b1, 0);
        run_op("dbz_s",    64'h1234, 64'd0, 1'b1, 0);
        run_op("dbz_u",    64'h1234, 64'd0, 1'b0, 0);
        run_op("ovf_s",    64'h8000_0000_0000_0000, '1, 1'b1, 0);
        run_op("ovf_u",    64'h8000_0000_0000_0000, '1, 1'b0, 0);
        run_op("u_max_1",  '1, 64'd1, 1'b0, 0);
        run_op("u_small_big", 64'd3, '1, 1'b0, 0);
        run_op("ignore_start", 64'd1000, 64'd3, 1'b0, 10);

        // Reset mid-operation: outputs clear at once and no done escapes
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 64'd12345; bus.divisor = 64'd11; bus.is_signed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst:busy", N'(bus.busy), '0);
        chk("midrst:done", N'(bus.done), '0);
        chk("midrst:quotient", bus.quotient, '0);
        chk("midrst:remainder", bus.remainder, '0);
        chk("midrst:dbz", N'(bus.div_by_zero), '0);
        no_done = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.done !== 1'b0) no_done = 1'b0;
        end
        rst_n = 1'b1;
        #1;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) no_done = 1'b0;
        chk("midrst:no_stale", N'(no_done), N'(1'b1));
        run_op("after_rst", -64'sd12345, 64'd100, 1'b1, 0);

        for (int i = 0; i < 250; i++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: rb = N'($urandom_range(1, 20));
                1: rb = -N'($urandom_range(1, 20));
                2: rb = N'($urandom);
                3: rb = ($urandom_range(0, 9) == 0) ? '0 : {$urandom, $urandom};
                4: rb = '1;
                default: rb = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 9) == 0) ra = 64'h8000_0000_0000_0000;
            run_op($sformatf("rnd%0d", i), ra, rb, 1'($urandom_range(0, 1)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
